// File: rtl/link_pkg.sv
// Shared constants and types for the byte-serial memory link.
package link_pkg;

    // Frame length and the phases that matter inside a frame.
    localparam int         FRAME_LEN   = 10;
    localparam logic [3:0] PH_TURN     = 4'd0;
    localparam logic [3:0] PH_CAP0     = 4'd1;
    localparam logic [3:0] PH_CAP_LAST = 4'd4;
    localparam logic [3:0] PH_ISSUE    = 4'd5;
    localparam logic [3:0] PH_RET0     = 4'd6;
    localparam logic [3:0] PH_LAST     = 4'(FRAME_LEN - 1);

    // Value of rw_in that marks a write frame.
    localparam logic RW_WRITE = 1'b1;

    typedef logic [31:0] link_word_t;

    // Request FSM: a local memory transaction is either outstanding or not.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } req_state_t;

endpackage

// File: rtl/link_shift32.sv
// Four-byte load/shift register. A shift moves every byte one lane down
// (towards byte 0) and inserts byte_i at byte 3. Used little-endian for
// both capture (bytes arrive lowest first) and return (byte 0 on the pins).
module link_shift32
    import link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  link_word_t load_val_i,
    input  logic       shift_i,
    input  logic [7:0] byte_i,
    output link_word_t q_o,
    output link_word_t d_o
);

    link_word_t word_q;
    link_word_t word_d;

    // Next value: load has priority over shift, otherwise hold.
    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = load_val_i;
        end else if (shift_i) begin
            word_d = {byte_i, word_q[31:8]};
        end
    end

    // Word register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;
    assign d_o = word_d;

endmodule

// File: rtl/link_responder.sv
// Target side of the byte-serial memory link. Runs a free 10-phase frame
// counter in lockstep with the initiator, captures address/write data in
// ph1-4, issues one local memory request at ph5 and returns read data on
// the shared pins in ph6-9.
//
// Local memory handshake: mem_req rises with mem_addr/mem_we/mem_wdata
// stable and stays high until the cycle in which mem_ack is sampled high;
// mem_ack is a one-cycle strobe, ignored while mem_req is low, and for a
// read it qualifies mem_rdata in that same cycle.
module link_responder
    import link_pkg::*;
#(
    parameter int RD_TIMEOUT_PH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_in,
    input  logic       rw_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       mem_req,
    output logic       mem_we,
    output link_word_t mem_addr,
    output link_word_t mem_wdata,
    input  link_word_t mem_rdata,
    input  logic       mem_ack,
    output logic       overrun,
    output logic [3:0] dbg_ph_o,
    output req_state_t dbg_state_o
);

    logic [3:0] ph_q;
    req_state_t state_q;
    logic       mem_req_q;
    logic       mem_we_q;
    link_word_t mem_addr_q;
    link_word_t mem_wdata_q;
    logic       rw_cap_q;
    logic       own_q;      // outstanding request was issued by the current frame
    logic       data_oe_q;
    logic       overrun_q;

    logic       capture;
    logic       ack_take;
    logic       rd_hit;
    link_word_t addr_cap_q, addr_cap_d;
    link_word_t wdata_cap_q, wdata_cap_d;
    link_word_t ret_q, ret_d;
    logic       unused_bits;

    // Capture window, ack acceptance and on-time read completion.
    assign capture  = (ph_q >= PH_CAP0) && (ph_q <= PH_CAP_LAST);
    assign ack_take = mem_ack && (state_q == PENDING);
    assign rd_hit   = ack_take && own_q && !mem_we_q
                      && (int'(ph_q) <= RD_TIMEOUT_PH);

    link_shift32 u_addr_cap (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (capture),
        .byte_i     (addr_in),
        .q_o        (addr_cap_q),
        .d_o        (addr_cap_d)
    );

    link_shift32 u_wdata_cap (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (capture),
        .byte_i     (data_in),
        .q_o        (wdata_cap_q),
        .d_o        (wdata_cap_d)
    );

    // Read buffer: loaded at the edge entering ph6 (zeros if the data is not
    // in time or the frame is a write), then shifted one byte per phase.
    link_shift32 u_ret (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ph_q == PH_ISSUE),
        .load_val_i (rd_hit ? mem_rdata : '0),
        .shift_i    (ph_q >= PH_RET0),
        .byte_i     (8'h00),
        .q_o        (ret_q),
        .d_o        (ret_d)
    );

    // Capture registers are consumed through their next-state value (the last
    // byte arrives on the issue edge); the return path only needs its register.
    assign unused_bits = ^{addr_cap_q, wdata_cap_q, ret_d};

    // Phase counter, request FSM, pin direction and overrun pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q        <= PH_TURN;
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rw_cap_q    <= 1'b0;
            own_q       <= 1'b0;
            data_oe_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            ph_q      <= (ph_q == PH_LAST) ? PH_TURN : ph_q + 4'd1;
            overrun_q <= 1'b0;

            if (ph_q == PH_CAP0) begin
                rw_cap_q <= rw_in;
            end

            // An accepted ack retires the request whatever the phase.
            if (ack_take) begin
                state_q   <= IDLE;
                mem_req_q <= 1'b0;
            end

            // Edge entering ph5: issue, or drop the frame if still busy. A
            // coincident ack has already freed the slot above.
            if (ph_q == PH_CAP_LAST) begin
                if ((state_q == IDLE) || ack_take) begin
                    state_q     <= PENDING;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= (rw_cap_q == RW_WRITE);
                    mem_addr_q  <= addr_cap_d;
                    mem_wdata_q <= wdata_cap_d;
                    own_q       <= 1'b1;
                end else begin
                    own_q     <= 1'b0;
                    overrun_q <= 1'b1;
                end
            end

            // Edge entering ph6: take the pins for a read frame; flag missing data.
            if (ph_q == PH_ISSUE) begin
                data_oe_q <= (rw_cap_q != RW_WRITE);
                if ((rw_cap_q != RW_WRITE) && !rd_hit) begin
                    overrun_q <= 1'b1;
                end
            end

            // Edge entering ph0: release the pins for the turnaround cycle.
            if (ph_q == PH_LAST) begin
                data_oe_q <= 1'b0;
            end
        end
    end

    assign data_out    = ret_q[7:0];
    assign data_oe     = data_oe_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign overrun     = overrun_q;
    assign dbg_ph_o    = ph_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_link_responder.sv
// Bench for link_responder: frame-level reference model driven by a plan of
// per-frame address/data/direction/ack-delay, checked every cycle.
module tb_link_responder;
    import link_pkg::*;

    localparam int TIMEOUT     = 5;
    localparam int NF          = 64;
    localparam int RESET_FRAME = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] addr_in, data_in, data_out;
    logic       rw_in, data_oe, mem_req, mem_we, mem_ack, overrun;
    link_word_t mem_addr, mem_wdata, mem_rdata;
    logic [3:0] dbg_ph_o;
    req_state_t dbg_state_o;

    link_responder #(.RD_TIMEOUT_PH(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .rw_in      (rw_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .overrun    (overrun),
        .dbg_ph_o   (dbg_ph_o),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- checking ----------------
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (time %0t)", tag, got, exp, $time);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " ph"},        dbg_ph_o, 0);
        check_eq({tag, " state"},     dbg_state_o, 0);
        check_eq({tag, " data_out"},  data_out, 0);
        check_eq({tag, " data_oe"},   data_oe, 0);
        check_eq({tag, " mem_req"},   mem_req, 0);
        check_eq({tag, " mem_we"},    mem_we, 0);
        check_eq({tag, " mem_addr"},  mem_addr, 0);
        check_eq({tag, " mem_wdata"}, mem_wdata, 0);
        check_eq({tag, " overrun"},   overrun, 0);
    endtask

    // ---------------- frame plan ----------------
    logic [31:0] fr_addr [NF];
    logic [31:0] fr_wdata[NF];
    logic [31:0] fr_rdata[NF];
    logic        fr_rw   [NF];
    int          fr_delay[NF];
    bit          fr_issued[NF];

    function automatic int pick_delay();
        case ($urandom_range(0, 9))
            5:       return 1;
            6:       return 3;
            7:       return 9;
            8:       return 12;
            9:       return 18;
            default: return 0;
        endcase
    endfunction

    // ---------------- reference model / scoreboard ----------------
    int          t, fbase;
    bit          out_valid;
    int          out_ack_t, out_frame;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;
    bit          did_reset;
    logic [7:0]  exp_q[$];

    task automatic model_reset();
        out_valid = 0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_we    = 1'b0;
        exp_q.delete();
    endtask

    // Check outputs of cycle t, drive inputs for cycle t, advance to t+1.
    task automatic cycle_step();
        int p, f;
        bit exp_ovr, ok_read, ret;
        logic [7:0] exp_byte;
        p = t % FRAME_LEN;
        f = fbase + t / FRAME_LEN;

        if (out_valid && out_ack_t == t - 1) out_valid = 0;
        exp_ovr = 0;
        if (p == 5) begin
            if (out_valid) begin
                exp_ovr = 1;
                fr_issued[f] = 0;
            end else begin
                out_valid = 1;
                out_ack_t = t + fr_delay[f];
                out_frame = f;
                exp_addr  = fr_addr[f];
                exp_wdata = fr_wdata[f];
                exp_we    = fr_rw[f];
                fr_issued[f] = 1;
            end
        end
        ret = (p >= 6) && (fr_rw[f] == 1'b0);
        if (p == 6 && ret) begin
            ok_read = fr_issued[f] && (fr_delay[f] <= TIMEOUT - 5);
            for (int k = 0; k < 4; k++)
                exp_q.push_back(ok_read ? fr_rdata[f][8*k +: 8] : 8'h00);
            if (!ok_read) exp_ovr = 1;
        end

        check_eq("ph", dbg_ph_o, p);
        check_eq("mem_req", mem_req, out_valid);
        check_eq("mem_addr", mem_addr, exp_addr);
        check_eq("mem_we", mem_we, exp_we);
        check_eq("mem_wdata", mem_wdata, exp_wdata);
        check_eq("overrun", overrun, exp_ovr);
        check_eq("data_oe", data_oe, ret);
        exp_byte = 8'h00;
        if (ret && exp_q.size() > 0) exp_byte = exp_q.pop_front();
        check_eq("data_out", data_out, exp_byte);

        addr_in = (p >= 1 && p <= 4) ? fr_addr[f][8*(p-1) +: 8]  : 8'($urandom);
        data_in = (p >= 1 && p <= 4) ? fr_wdata[f][8*(p-1) +: 8] : 8'($urandom);
        rw_in   = (p == 1) ? fr_rw[f] : 1'($urandom);
        if (out_valid && out_ack_t == t) begin
            mem_ack   = 1'b1;
            mem_rdata = fr_rdata[out_frame];
        end else begin
            mem_ack   = (!out_valid && p <= 4 && $urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
        if (f == RESET_FRAME && p == 7 && !did_reset) begin
            rst_n     = 1'b0;
            mem_ack   = 1'b0;
            did_reset = 1;
        end
        @(negedge clk);
        t++;
    endtask

    // ---------------- main ----------------
    initial begin
        rst_n = 1'b0; addr_in = '0; data_in = '0; rw_in = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; did_reset = 0;

        for (int f = 0; f < NF; f++) begin
            fr_addr[f]  = $urandom;
            fr_wdata[f] = $urandom;
            fr_rdata[f] = $urandom;
            fr_rw[f]    = 1'($urandom_range(0, 1));
            fr_delay[f] = pick_delay();
            fr_issued[f] = 0;
        end
        // Zero-wait read.
        fr_addr[0] = 32'h1234_5678; fr_rw[0] = 1'b0; fr_delay[0] = 0; fr_rdata[0] = 32'hCAFE_BABE;
        // Write.
        fr_addr[1] = 32'h0000_0010; fr_wdata[1] = 32'h1122_3344; fr_rw[1] = 1'b1; fr_delay[1] = 0;
        // Late ack in ph7.
        fr_rw[2] = 1'b0; fr_delay[2] = 2;
        // Ack withheld 15 cycles: frame 4 is dropped.
        fr_rw[3] = 1'b0; fr_delay[3] = 15;
        fr_rw[4] = 1'b0;
        // Ack in ph4 of the next frame coincides with its issue.
        fr_rw[5] = 1'b1; fr_delay[5] = 9;
        // Three consecutive zero-wait reads.
        for (int f = 6; f <= 8; f++) begin fr_rw[f] = 1'b0; fr_delay[f] = 0; end
        fr_rw[9] = 1'b1; fr_delay[9] = 1;
        // Long read still pending when reset hits at ph7.
        fr_rw[RESET_FRAME] = 1'b0; fr_delay[RESET_FRAME] = 30;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        t = 0; fbase = 0;
        model_reset();

        while (fbase + t / FRAME_LEN < NF) begin
            cycle_step();
            if (!rst_n) begin
                check_reset("midreset");
                rst_n = 1'b1;
                t = 0;
                fbase = RESET_FRAME + 1;
                model_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
